// File: rtl/packet_link_arbiter.sv
// ---------------------------------------------------------------------------
// packet_link_arbiter
//
// Packet-granular round-robin arbiter sharing one flit output channel between
// NUM_REQ flit sources. The winning source keeps the channel from its first
// flit through its tail flit (wormhole lock), so packets never interleave. A
// watchdog force-releases a lock once a packet reaches MAX_PKT_FLITS flits
// without a tail.
//
// Datapath is purely combinational (0-cycle latency). Only the arbitration
// state (IDLE/LOCKED, round-robin pointer, lock owner, flit counter, overrun
// pulse) is registered.
//
// Ports
//   nocclk          in   clock, all state on rising edge
//   rst_n           in   asynchronous active-low reset
//   in_flit         in   NUM_REQ packed flits, source i at [i*FLIT_W +: FLIT_W]
//   in_flit_is_tail in   per-source tail marker for the presented flit
//   in_flit_valid   in   per-source valid
//   in_flit_ready   out  per-source ready
//   out_flit        out  flit of the granted source
//   out_flit_valid  out  granted flit valid
//   out_flit_ready  in   downstream ready
//   grant_id        out  current (or candidate) grantee
//   locked          out  high while a packet holds the channel
//   pkt_overrun     out  one-cycle pulse after a watchdog release
// ---------------------------------------------------------------------------
package types;
    typedef logic [31:0] flit_t;
endpackage

module packet_link_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int MAX_PKT_FLITS = 16,
    localparam int FLIT_W       = $bits(types::flit_t),
    localparam int ID_W         = $clog2(NUM_REQ),
    localparam int CNT_W        = $clog2(MAX_PKT_FLITS + 1)
) (
    input  logic                        nocclk,
    input  logic                        rst_n,
    input  logic [NUM_REQ*FLIT_W-1:0]   in_flit,
    input  logic [NUM_REQ-1:0]          in_flit_is_tail,
    input  logic [NUM_REQ-1:0]          in_flit_valid,
    output logic [NUM_REQ-1:0]          in_flit_ready,
    output types::flit_t                out_flit,
    output logic                        out_flit_valid,
    input  logic                        out_flit_ready,
    output logic [ID_W-1:0]             grant_id,
    output logic                        locked,
    output logic                        pkt_overrun
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_reg,    state_next;
    logic [ID_W-1:0]    rr_ptr_reg,   rr_ptr_next;
    logic [ID_W-1:0]    lock_id_reg,  lock_id_next;
    logic [CNT_W-1:0]   flit_cnt_reg, flit_cnt_next;
    logic               overrun_reg,  overrun_next;

    types::flit_t       flit_arr [NUM_REQ];

    logic               found;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    sel_id;
    logic               sel_valid;
    logic               sel_tail;
    logic               grant_open;
    logic               xfer;

    // Successor in the ring; explicit compare so non-power-of-2 counts wrap
    // to 0 instead of walking into unused codes.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

    // Unpack the flat flit bus into one entry per source.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign flit_arr[gi] = in_flit[gi*FLIT_W +: FLIT_W];
    end

    // Round-robin search starting at rr_ptr. The sum is one bit wider than
    // an id so rr_ptr + k never overflows before the modulo correction.
    always_comb begin
        logic [ID_W:0] cand;
        found  = 1'b0;
        winner = rr_ptr_reg;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && in_flit_valid[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    // While locked the owner alone is eligible, even if it is bubbling.
    always_comb begin
        if (state_reg == ST_LOCKED) begin
            sel_id     = lock_id_reg;
            sel_valid  = in_flit_valid[lock_id_reg];
            grant_open = 1'b1;
        end else begin
            sel_id     = winner;
            sel_valid  = found;
            grant_open = found;
        end
    end

    assign sel_tail = in_flit_is_tail[sel_id];
    assign xfer     = out_flit_valid && out_flit_ready;

    // Outputs are forced to their idle values while reset is asserted so
    // nothing leaks downstream before the state registers are meaningful.
    assign out_flit_valid = rst_n && sel_valid;
    assign out_flit       = rst_n ? flit_arr[sel_id] : '0;
    assign grant_id       = rst_n ? sel_id : '0;
    assign locked         = rst_n && (state_reg == ST_LOCKED);
    assign pkt_overrun    = rst_n && overrun_reg;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign in_flit_ready[gi] = rst_n && out_flit_ready && grant_open &&
                                   (sel_id == ID_W'(gi));
    end

    // Next-state logic. A tail always wins over the watchdog, so a packet of
    // exactly MAX_PKT_FLITS flits ending in a tail releases normally.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        lock_id_next  = lock_id_reg;
        flit_cnt_next = flit_cnt_reg;
        overrun_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (xfer) begin
                    if (sel_tail) begin
                        rr_ptr_next = wrap_inc(winner);
                    end else begin
                        state_next    = ST_LOCKED;
                        lock_id_next  = winner;
                        flit_cnt_next = CNT_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    if (sel_tail) begin
                        state_next    = ST_IDLE;
                        rr_ptr_next   = wrap_inc(lock_id_reg);
                        flit_cnt_next = '0;
                    end else if (flit_cnt_reg == CNT_W'(MAX_PKT_FLITS - 1)) begin
                        // The over-long flit is still delivered; only the lock
                        // is dropped so other sources can make progress.
                        state_next    = ST_IDLE;
                        rr_ptr_next   = wrap_inc(lock_id_reg);
                        flit_cnt_next = '0;
                        overrun_next  = 1'b1;
                    end else begin
                        flit_cnt_next = flit_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            lock_id_reg  <= '0;
            flit_cnt_reg <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            lock_id_reg  <= lock_id_next;
            flit_cnt_reg <= flit_cnt_next;
            overrun_reg  <= overrun_next;
        end
    end

endmodule

// File: tb/tb_packet_link_arbiter.sv
// ---------------------------------------------------------------------------
// tb_packet_link_arbiter
//
// Directed bench for packet_link_arbiter (NUM_REQ=2, MAX_PKT_FLITS=4).
// Per-source queues model the flit sources; every expected delivery is pushed
// into a scoreboard when the stimulus is set up, and an independent monitor
// pops and compares on every output handshake.
// Flit encoding: {src[7:0], pkt[7:0], idx[15:0]}.
// ---------------------------------------------------------------------------
module tb_packet_link_arbiter;

    localparam int N    = 2;
    localparam int MAXF = 4;
    localparam int FW   = $bits(types::flit_t);

    logic                nocclk = 1'b0;
    logic                rst_n;
    logic [N*FW-1:0]     in_flit;
    logic [N-1:0]        in_flit_is_tail;
    logic [N-1:0]        in_flit_valid;
    logic [N-1:0]        in_flit_ready;
    types::flit_t        out_flit;
    logic                out_flit_valid;
    logic                out_flit_ready;
    logic [0:0]          grant_id;
    logic                locked;
    logic                pkt_overrun;

    packet_link_arbiter #(
        .NUM_REQ       (N),
        .MAX_PKT_FLITS (MAXF)
    ) dut (
        .nocclk          (nocclk),
        .rst_n           (rst_n),
        .in_flit         (in_flit),
        .in_flit_is_tail (in_flit_is_tail),
        .in_flit_valid   (in_flit_valid),
        .in_flit_ready   (in_flit_ready),
        .out_flit        (out_flit),
        .out_flit_valid  (out_flit_valid),
        .out_flit_ready  (out_flit_ready),
        .grant_id        (grant_id),
        .locked          (locked),
        .pkt_overrun     (pkt_overrun)
    );

    always #5 nocclk = ~nocclk;

    typedef struct packed {
        types::flit_t f;
        logic         tail;
    } src_ent_t;

    typedef struct packed {
        types::flit_t f;
        logic [0:0]   gid;
    } exp_ent_t;

    src_ent_t   q0[$];
    src_ent_t   q1[$];
    exp_ent_t   exp_q[$];

    int         checks = 0;
    int         errors = 0;
    logic [1:0] vmask  = 2'b00;
    logic       last_locked;
    int         ovr_cnt = 0;

    function automatic types::flit_t mk(input int src, input int pkt, input int idx);
        return {8'(src), 8'(pkt), 16'(idx)};
    endfunction

    // Queue a packet at a source; with_tail=0 models a runaway packet.
    task automatic add_pkt(input int src, input int pkt, input int nflits, input bit with_tail);
        src_ent_t e;
        for (int i = 0; i < nflits; i++) begin
            e.f    = mk(src, pkt, i);
            e.tail = with_tail && (i == nflits - 1);
            if (src == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    task automatic expect_flit(input int src, input int pkt, input int idx, input int gid);
        exp_ent_t e;
        e.f   = mk(src, pkt, idx);
        e.gid = 1'(gid);
        exp_q.push_back(e);
    endtask

    task automatic drive();
        in_flit_valid[0]   = (q0.size() > 0) && vmask[0];
        in_flit_valid[1]   = (q1.size() > 0) && vmask[1];
        in_flit[0*FW +: FW] = (q0.size() > 0) ? q0[0].f : '0;
        in_flit[1*FW +: FW] = (q1.size() > 0) ? q1[0].f : '0;
        in_flit_is_tail[0] = (q0.size() > 0) ? q0[0].tail : 1'b0;
        in_flit_is_tail[1] = (q1.size() > 0) ? q1[0].tail : 1'b0;
    endtask

    // One clock: present inputs, sample at the falling edge, retire the
    // source heads that handshook at the rising edge.
    task automatic run_cycle(input logic rdy, input logic [1:0] m);
        logic [1:0] hs;
        out_flit_ready = rdy;
        vmask          = m;
        drive();
        @(negedge nocclk);
        hs          = in_flit_valid & in_flit_ready;
        last_locked = locked;
        if (pkt_overrun) ovr_cnt++;
        @(posedge nocclk);
        #1;
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        drive();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic run_until_empty(input string name, input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            run_cycle(1'b1, 2'b11);
            n++;
        end
        chk({name, "_drain_left"}, 32'(q0.size() + q1.size()), 32'd0);
        run_cycle(1'b1, 2'b11);
    endtask

    // Scoreboard monitor: one line per delivered flit.
    initial begin
        exp_ent_t e;
        forever begin
            @(negedge nocclk);
            if (rst_n === 1'b1 && out_flit_valid === 1'b1 && out_flit_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected actual=%h gid=%0d required=none", out_flit, grant_id);
                end else begin
                    e = exp_q.pop_front();
                    if (out_flit !== e.f || grant_id !== e.gid) begin
                        errors++;
                        $display("FAIL sb_flit actual=%h gid=%0d required=%h gid=%0d",
                                 out_flit, grant_id, e.f, e.gid);
                    end else begin
                        $display("xfer gid=%0d flit=%h", grant_id, out_flit);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with every source valid
        rst_n           = 1'b0;
        out_flit_ready  = 1'b1;
        in_flit_valid   = 2'b11;
        in_flit_is_tail = 2'b11;
        in_flit         = {32'hBEEF_0001, 32'hCAFE_0000};
        repeat (2) @(negedge nocclk);
        chk("rst_out_valid",   32'(out_flit_valid), 32'd0);
        chk("rst_in_ready",    32'(in_flit_ready),  32'd0);
        chk("rst_locked",      32'(locked),         32'd0);
        chk("rst_overrun",     32'(pkt_overrun),    32'd0);
        chk("rst_grant_id",    32'(grant_id),       32'd0);
        chk("rst_out_flit",    32'(out_flit),       32'd0);
        #2 rst_n = 1'b1;
        vmask = 2'b00;
        drive();
        @(posedge nocclk);
        #1;

        // 2: fairness, both sources stream single-flit packets
        for (int p = 1; p <= 3; p++) begin
            add_pkt(0, p, 1, 1'b1);
            add_pkt(1, p, 1, 1'b1);
            expect_flit(0, p, 0, 0);
            expect_flit(1, p, 0, 1);
        end
        run_until_empty("fair", 20);
        chk("fair_sb_left", 32'(exp_q.size()), 32'd0);

        // 3: 4-flit packet from src0 holds the channel against src1
        ovr_cnt = 0;
        add_pkt(0, 10, 4, 1'b1);
        add_pkt(1, 11, 1, 1'b1);
        add_pkt(1, 12, 1, 1'b1);
        for (int i = 0; i < 4; i++) expect_flit(0, 10, i, 0);
        expect_flit(1, 11, 0, 1);
        expect_flit(1, 12, 0, 1);
        for (int k = 0; k < 6; k++) begin
            run_cycle(1'b1, 2'b11);
            chk($sformatf("lock_locked_c%0d", k), 32'(last_locked),
                32'((k >= 1 && k <= 3) ? 1 : 0));
        end
        run_until_empty("lock", 10);
        chk("lock_no_overrun", 32'(ovr_cnt), 32'd0);
        chk("lock_sb_left", 32'(exp_q.size()), 32'd0);

        // 4: downstream stall then source bubble in the middle of a packet
        add_pkt(0, 20, 4, 1'b1);
        add_pkt(1, 21, 1, 1'b1);
        for (int i = 0; i < 4; i++) expect_flit(0, 20, i, 0);
        expect_flit(1, 21, 0, 1);
        run_cycle(1'b1, 2'b11);
        for (int k = 0; k < 3; k++) begin
            run_cycle(1'b0, 2'b11);
            chk($sformatf("bp_stall_locked_%0d", k), 32'(last_locked), 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            run_cycle(1'b1, 2'b10);
            chk($sformatf("bp_bubble_locked_%0d", k), 32'(last_locked), 32'd1);
        end
        chk("bp_src0_left", 32'(q0.size()), 32'd3);
        run_until_empty("bp", 20);
        chk("bp_sb_left", 32'(exp_q.size()), 32'd0);

        // 5: watchdog, src1 streams 6 flits with no tail, src0 waits
        ovr_cnt = 0;
        add_pkt(1, 30, 6, 1'b0);
        expect_flit(1, 30, 0, 1);
        run_cycle(1'b1, 2'b11);
        add_pkt(0, 31, 1, 1'b1);
        for (int i = 1; i < 4; i++) expect_flit(1, 30, i, 1);
        expect_flit(0, 31, 0, 0);
        expect_flit(1, 30, 4, 1);
        expect_flit(1, 30, 5, 1);
        run_until_empty("wdog", 20);
        chk("wdog_overrun_pulses", 32'(ovr_cnt), 32'd1);
        chk("wdog_sb_left", 32'(exp_q.size()), 32'd0);
        chk("wdog_relocked", 32'(last_locked), 32'd1);

        // 6: asynchronous reset while src1 holds a 2-flit lock
        @(posedge nocclk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_locked",    32'(locked),         32'd0);
        chk("areset_out_valid", 32'(out_flit_valid), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge nocclk);
        #1;
        add_pkt(0, 40, 1, 1'b1);
        add_pkt(1, 41, 1, 1'b1);
        expect_flit(0, 40, 0, 0);
        expect_flit(1, 41, 0, 1);
        run_until_empty("areset", 10);
        chk("areset_sb_left", 32'(exp_q.size()), 32'd0);
        chk("areset_idle", 32'(last_locked), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
